// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and receiver.
//   - FSM state encodings (3-bit, plain localparams so legacy code can reuse them)
//   - Default bit timing: 115200 baud at 217 system clocks per bit
package uart_pkg;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START      = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] STOP       = 3'd3;
    localparam logic [2:0] BREAK_WAIT = 3'd4;

    localparam int BAUD_RATE          = 115200;
    localparam int CLOCK_PER_BIT      = 217;
    localparam int HALF_CLOCK_PER_BIT = 108;

    // Width of the bit-period counter; bit timing counts must stay below 2**CNT_W.
    localparam int CNT_W = 12;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clock   - destination clock domain
//   reset_n - asynchronous active-low reset; both flops load reset_value
//   d       - asynchronous input
//   q       - synchronised output (two clocks of latency)
module sync_2ff #(
    parameter logic reset_value = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= reset_value;
            q    <= reset_value;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/receiver.sv
// receiver: UART receive stage, 8N1, LSB first.
// Synchronises rx, qualifies the start bit at its midpoint, samples eight data
// bits at mid-bit, checks the stop bit and hands each byte to the consumer
// through a valid/ack holding register.
// Ports:
//   clock         - system clock, all logic on posedge
//   reset_n       - asynchronous active-low reset
//   rx            - serial line, idle high, asynchronous to clock
//   data          - last delivered byte, stable while data_valid=1
//   data_valid    - set on delivery, cleared by data_ack
//   data_ack      - consumer read strobe
//   busy          - high whenever a frame is being received or a break is pending
//   framing_error - one-cycle pulse when the stop bit samples low
//   overrun       - one-cycle pulse when a byte arrives while the previous one is unread
module receiver
    import uart_pkg::*;
#(
    parameter int baud_rate          = BAUD_RATE,
    parameter int clock_per_bit      = CLOCK_PER_BIT,
    parameter int half_clock_per_bit = HALF_CLOCK_PER_BIT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       busy,
    output logic       framing_error,
    output logic       overrun
);

    // Timing parameters that cannot be represented by the counter, or a
    // nonsensical baud rate, leave the receiver permanently idle rather than
    // producing garbage frames.
    localparam bit PARAMS_OK = (baud_rate > 0) &&
                               (clock_per_bit < (1 << CNT_W)) &&
                               (half_clock_per_bit > 0) &&
                               (half_clock_per_bit < clock_per_bit);

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(clock_per_bit - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(half_clock_per_bit - 1);

    logic             rx_sync;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;

    logic stop_sample;
    logic deliver;
    logic frame_bad;

    sync_2ff #(
        .reset_value(1'b1)
    ) u_rx_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (rx),
        .q      (rx_sync)
    );

    assign busy        = (state != IDLE);
    assign stop_sample = (state == STOP) && (cnt == CNT_BIT_LAST);
    assign deliver     = stop_sample &&  rx_sync;
    assign frame_bad   = stop_sample && !rx_sync;

    // Frame FSM. The counter is cleared on every state change so each state
    // measures its own interval from entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_sync && PARAMS_OK) begin
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_sync) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            // Line went high again before mid start bit: a glitch.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_BIT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_sync;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (stop_sample) begin
                        cnt   <= '0;
                        state <= rx_sync ? IDLE : BREAK_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK_WAIT: begin
                    // A held-low line must go high before another start bit
                    // can be recognised.
                    cnt <= '0;
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Consumer-side holding register. An ack on the delivery edge frees the
    // slot in time for the new byte, so no overrun is raised in that case.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_bad;
            overrun       <= deliver && data_valid && !data_ack;
            if (deliver && (!data_valid || data_ack)) begin
                data       <= shift;
                data_valid <= 1'b1;
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_receiver.sv
module tb_receiver;

    localparam int CPB     = 217;
    localparam int LAT     = 2064;
    localparam int LAT_TOL = 2;

    logic       clock;
    logic       reset_n;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       busy;
    logic       framing_error;
    logic       overrun;

    receiver dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx           (rx),
        .data         (data),
        .data_valid   (data_valid),
        .data_ack     (data_ack),
        .busy         (busy),
        .framing_error(framing_error),
        .overrun      (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Free-running event monitors; the test takes before/after differences.
    int   cyc       = 0;
    int   fe_total  = 0;
    int   ov_total  = 0;
    int   dv_rises  = 0;
    int   dv_rise_cyc = 0;
    logic prev_dv   = 1'b0;
    int   fall_cyc  = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (framing_error === 1'b1) fe_total++;
        if (overrun === 1'b1) ov_total++;
        if (data_valid === 1'b1 && prev_dv !== 1'b1) begin
            dv_rises++;
            dv_rise_cyc = cyc;
        end
        prev_dv = data_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_ack();
        @(posedge clock);
        #1 data_ack = 1'b1;
        @(posedge clock);
        #1 data_ack = 1'b0;
    endtask

    // Drives one 8N1 frame. When release_line is 0 the line is left at the
    // stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit release_line);
        @(posedge clock);
        #1;
        fall_cyc = cyc;
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CPB);
        end
        rx = stop;
        hold(CPB);
        if (release_line) begin
            rx = 1'b1;
            hold(20);
        end
    endtask

    typedef struct {
        logic [7:0] byte_in;
        logic       stop_in;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_fe;
    } vec_t;

    vec_t vecs[5];

    int fe0, ov0, dv0;

    initial begin
        vecs[0] = '{byte_in: 8'hA5, stop_in: 1'b1, exp_data: 8'hA5, exp_valid: 1'b1, exp_fe: 0};
        vecs[1] = '{byte_in: 8'h00, stop_in: 1'b1, exp_data: 8'h00, exp_valid: 1'b1, exp_fe: 0};
        vecs[2] = '{byte_in: 8'hFF, stop_in: 1'b1, exp_data: 8'hFF, exp_valid: 1'b1, exp_fe: 0};
        vecs[3] = '{byte_in: 8'h3C, stop_in: 1'b0, exp_data: 8'hFF, exp_valid: 1'b0, exp_fe: 1};
        vecs[4] = '{byte_in: 8'h81, stop_in: 1'b1, exp_data: 8'h81, exp_valid: 1'b1, exp_fe: 0};

        rx       = 1'b1;
        data_ack = 1'b0;
        reset_n  = 1'b0;
        hold(4);

        check("reset_data", data, 8'h00);
        check("reset_valid", data_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_fe", framing_error, 1'b0);
        check("reset_ov", overrun, 1'b0);

        reset_n = 1'b1;
        hold(10);

        // Table of single frames, slot cleared before each one.
        for (int v = 0; v < 5; v++) begin
            pulse_ack();
            fe0 = fe_total;
            dv0 = dv_rises;
            send_frame(vecs[v].byte_in, vecs[v].stop_in, 1'b1);
            check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
            check($sformatf("vec%0d_valid", v), data_valid, vecs[v].exp_valid);
            check($sformatf("vec%0d_fe", v), fe_total - fe0, vecs[v].exp_fe);
            check($sformatf("vec%0d_busy", v), busy, 1'b0);
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d_rise", v), dv_rises - dv0, 1);
                check_range($sformatf("vec%0d_latency", v), dv_rise_cyc - fall_cyc,
                            LAT - LAT_TOL, LAT + LAT_TOL);
            end
        end

        // Short low glitch from idle.
        pulse_ack();
        fe0 = fe_total;
        ov0 = ov_total;
        dv0 = dv_rises;
        @(posedge clock);
        #1 rx = 1'b0;
        hold(20);
        check("glitch_busy_during", busy, 1'b1);
        hold(30);
        rx = 1'b1;
        hold(200);
        check("glitch_busy_after", busy, 1'b0);
        check("glitch_valid", data_valid, 1'b0);
        check("glitch_fe", fe_total - fe0, 0);
        check("glitch_ov", ov_total - ov0, 0);
        check("glitch_rise", dv_rises - dv0, 0);

        // Bad stop bit followed by a long break, then a good frame.
        fe0 = fe_total;
        dv0 = dv_rises;
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(3000);
        check("break_fe", fe_total - fe0, 1);
        check("break_valid", data_valid, 1'b0);
        check("break_busy", busy, 1'b1);
        check("break_rise", dv_rises - dv0, 0);
        rx = 1'b1;
        hold(20);
        check("break_release_busy", busy, 1'b0);
        send_frame(8'h81, 1'b1, 1'b1);
        check("after_break_data", data, 8'h81);
        check("after_break_valid", data_valid, 1'b1);
        check("after_break_fe", fe_total - fe0, 1);

        // Back-to-back with no ack: second byte dropped.
        pulse_ack();
        ov0 = ov_total;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        check("ovr_data", data, 8'h11);
        check("ovr_valid", data_valid, 1'b1);
        check("ovr_pulses", ov_total - ov0, 1);
        pulse_ack();
        #1;
        check("ovr_ack_clears", data_valid, 1'b0);
        check("ovr_ack_data_held", data, 8'h11);

        // Ack lands on the same edge as the second byte's stop sample.
        ov0 = ov_total;
        send_frame(8'h11, 1'b1, 1'b0);
        fork
            send_frame(8'h22, 1'b1, 1'b1);
            begin
                @(posedge clock);
                repeat (LAT - 1) @(posedge clock);
                #1 data_ack = 1'b1;
                @(posedge clock);
                #1 data_ack = 1'b0;
            end
        join
        check("coinc_data", data, 8'h22);
        check("coinc_valid", data_valid, 1'b1);
        check("coinc_ov", ov_total - ov0, 0);

        // Reset in the middle of a 0xFF frame, then a clean 0x5A.
        @(posedge clock);
        #1 rx = 1'b0;
        hold(CPB);
        rx = 1'b1;
        hold(400);
        check("pre_reset_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset_data", data, 8'h00);
        check("midreset_valid", data_valid, 1'b0);
        check("midreset_busy", busy, 1'b0);
        hold(3);
        reset_n = 1'b1;
        dv0 = dv_rises;
        fe0 = fe_total;
        hold(1800);
        check("postreset_busy", busy, 1'b0);
        check("postreset_valid", data_valid, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b1);
        check("postreset_data", data, 8'h5A);
        check("postreset_rises", dv_rises - dv0, 1);
        check("postreset_fe", fe_total - fe0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
